// File: rtl/player_move_ctrl.sv
// Decodes PS/2 set-2 make/break/E0 scan bytes into held keys for two players and
// moves each player once per FRAME_DIV eof pulses, clamped to the playfield.
// Optional build macro DIAG_EN: when defined, x and y may both change on one tick.
module player_move_ctrl #(
  parameter int W         = 11,
  parameter int XMIN      = 0,
  parameter int XMAX      = 799,
  parameter int YMIN      = 0,
  parameter int YMAX      = 599,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int P0_X0     = 200,
  parameter int P0_Y0     = 300,
  parameter int P1_X0     = 600,
  parameter int P1_Y0     = 300
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                eof,
  input  logic                data_valid,
  input  logic [7:0]          data,
  output logic signed [W-1:0] p0_x,
  output logic signed [W-1:0] p0_y,
  output logic signed [W-1:0] p1_x,
  output logic signed [W-1:0] p1_y,
  output logic [7:0]          keys
);

  localparam int unsigned PW = W;
  localparam int unsigned AW = W + 1;
  localparam int unsigned CW = 8;

  localparam logic [CW-1:0]      FRAME_LAST = CW'(FRAME_DIV - 1);
  localparam logic signed [W:0]  STEP_S     = AW'(STEP);
  localparam logic signed [W:0]  X_LO       = AW'(XMIN);
  localparam logic signed [W:0]  X_HI       = AW'(XMAX);
  localparam logic signed [W:0]  Y_LO       = AW'(YMIN);
  localparam logic signed [W:0]  Y_HI       = AW'(YMAX);

  // Byte k of this table is the scan code for keys bit k; bits 7:4 need the E0 prefix.
  localparam logic [63:0] KEY_CODES = {8'h74, 8'h6B, 8'h72, 8'h75,
                                       8'h23, 8'h15, 8'h1B, 8'h1A};

  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_e;

  state_e             state_q, state_d;
  logic [7:0]         keys_q, keys_d;
  logic [CW-1:0]      frame_q, frame_d;
  logic signed [W-1:0] p0_x_q, p0_x_d, p0_y_q, p0_y_d;
  logic signed [W-1:0] p1_x_q, p1_x_d, p1_y_q, p1_y_d;
  logic               make_ev, brk_ev, ev_ext, tick, p0_x_en, p1_x_en;

  // One axis step in W+1 bits so a move past a bound saturates instead of wrapping.
  function automatic logic signed [W-1:0] axis_move(
    input logic signed [W-1:0] pos,
    input logic                inc,
    input logic                dec,
    input logic                en,
    input logic signed [W:0]   lo,
    input logic signed [W:0]   hi
  );
    logic signed [W:0] sum;
    sum = {pos[W-1], pos};
    if (en && inc && !dec)      sum = sum + STEP_S;
    else if (en && dec && !inc) sum = sum - STEP_S;
    if (sum > hi)      sum = hi;
    else if (sum < lo) sum = lo;
    return sum[W-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    keys_d  = keys_q;
    frame_d = frame_q;
    p0_x_d  = p0_x_q;
    p0_y_d  = p0_y_q;
    p1_x_d  = p1_x_q;
    p1_y_d  = p1_y_q;
    make_ev = 1'b0;
    brk_ev  = 1'b0;
    ev_ext  = 1'b0;

    if (data_valid) begin
      case (state_q)
        IDLE: begin
          if (data == 8'hF0)      state_d = BRK;
          else if (data == 8'hE0) state_d = EXT;
          else                    make_ev = 1'b1;
        end
        BRK: begin
          brk_ev  = 1'b1;
          state_d = IDLE;
        end
        EXT: begin
          ev_ext = 1'b1;
          if (data == 8'hF0) state_d = EXT_BRK;
          else begin
            make_ev = 1'b1;
            state_d = IDLE;
          end
        end
        default: begin
          ev_ext  = 1'b1;
          brk_ev  = 1'b1;
          state_d = IDLE;
        end
      endcase
    end

    // Codes with the wrong prefix or no table entry leave keys untouched.
    for (int k = 0; k < 8; k++) begin
      if ((data == KEY_CODES[k*8 +: 8]) && (ev_ext == (k >= 4))) begin
        if (make_ev) keys_d[k] = 1'b1;
        if (brk_ev)  keys_d[k] = 1'b0;
      end
    end

    tick = eof && (frame_q == FRAME_LAST);
    if (eof) frame_d = tick ? '0 : frame_q + CW'(1);

`ifdef DIAG_EN
    p0_x_en = 1'b1;
    p1_x_en = 1'b1;
`else
    p0_x_en = !(keys_q[0] ^ keys_q[1]);
    p1_x_en = !(keys_q[4] ^ keys_q[5]);
`endif

    // Moves use keys_q, so a byte landing with eof only affects the following tick.
    if (tick) begin
      p0_x_d = axis_move(p0_x_q, keys_q[3], keys_q[2], p0_x_en, X_LO, X_HI);
      p0_y_d = axis_move(p0_y_q, keys_q[1], keys_q[0], 1'b1,    Y_LO, Y_HI);
      p1_x_d = axis_move(p1_x_q, keys_q[7], keys_q[6], p1_x_en, X_LO, X_HI);
      p1_y_d = axis_move(p1_y_q, keys_q[5], keys_q[4], 1'b1,    Y_LO, Y_HI);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      keys_q  <= '0;
      frame_q <= '0;
      p0_x_q  <= PW'(P0_X0);
      p0_y_q  <= PW'(P0_Y0);
      p1_x_q  <= PW'(P1_X0);
      p1_y_q  <= PW'(P1_Y0);
    end else begin
      state_q <= state_d;
      keys_q  <= keys_d;
      frame_q <= frame_d;
      p0_x_q  <= p0_x_d;
      p0_y_q  <= p0_y_d;
      p1_x_q  <= p1_x_d;
      p1_y_q  <= p1_y_d;
    end
  end

  assign p0_x = p0_x_q;
  assign p0_y = p0_y_q;
  assign p1_x = p1_x_q;
  assign p1_y = p1_y_q;
  assign keys = keys_q;

endmodule

// File: tb/tb_player_move_ctrl.sv
// Scoreboard bench for player_move_ctrl: a default instance and a FRAME_DIV=3/STEP=4
// instance share stimulus; a key-set/prefix-flag model predicts every cycle.
module tb_player_move_ctrl;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic eof = 1'b0;
  logic data_valid = 1'b0;
  logic [7:0] data = 8'h00;

  logic signed [10:0] a_p0x, a_p0y, a_p1x, a_p1y, b_p0x, b_p0y, b_p1x, b_p1y;
  logic [7:0] a_keys, b_keys;

  always #5 clk = ~clk;

  player_move_ctrl dut_a (
    .clk(clk), .reset_n(reset_n), .eof(eof), .data_valid(data_valid), .data(data),
    .p0_x(a_p0x), .p0_y(a_p0y), .p1_x(a_p1x), .p1_y(a_p1y), .keys(a_keys)
  );

  player_move_ctrl #(.FRAME_DIV(3), .STEP(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .eof(eof), .data_valid(data_valid), .data(data),
    .p0_x(b_p0x), .p0_y(b_p0y), .p1_x(b_p1x), .p1_y(b_p1y), .keys(b_keys)
  );

  typedef struct packed {
    logic [7:0]         keys;
    logic signed [15:0] x0, y0, x1, y1;
  } obs_t;

  obs_t qa[$], qb[$];
  int checks = 0;
  int errors = 0;

  // Reference model: held-key set, pending break/extended flags, per-instance frame count.
  bit [7:0] mkeys;
  bit       mbrk, mext;
  int       mcnt[2];
  int       mx[2][2], my[2][2];

  function automatic int fdiv(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  function automatic int stepsz(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic bit [7:0] key_code(input int k);
    case (k)
      0: return 8'h1A; 1: return 8'h1B; 2: return 8'h15; 3: return 8'h23;
      4: return 8'h75; 5: return 8'h72; 6: return 8'h6B; default: return 8'h74;
    endcase
  endfunction

  function automatic int clampi(input int v, input int lo, input int hi);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  task automatic set_key(input bit [7:0] b, input bit ext, input bit val);
    for (int k = 0; k < 8; k++)
      if (key_code(k) == b && ext == (k >= 4)) mkeys[k] = val;
  endtask

  task automatic model_step(input bit r, input bit e, input bit v, input bit [7:0] b);
    bit [7:0] old;
    int u, d, l, rt, dx, dy;
    if (!r) begin
      mkeys = '0; mbrk = 0; mext = 0;
      for (int i = 0; i < 2; i++) begin
        mcnt[i] = 0;
        mx[i][0] = 200; my[i][0] = 300;
        mx[i][1] = 600; my[i][1] = 300;
      end
      return;
    end
    old = mkeys;
    if (v) begin
      if (mbrk) begin
        set_key(b, mext, 1'b0); mbrk = 0; mext = 0;
      end else if (b == 8'hF0) mbrk = 1;
      else if (b == 8'hE0 && !mext) mext = 1;
      else begin
        set_key(b, mext, 1'b1); mext = 0;
      end
    end
    for (int i = 0; i < 2; i++) begin
      if (e) begin
        if (mcnt[i] == fdiv(i) - 1) begin
          mcnt[i] = 0;
          for (int p = 0; p < 2; p++) begin
            u = int'(old[4*p]); d = int'(old[4*p+1]);
            l = int'(old[4*p+2]); rt = int'(old[4*p+3]);
            dy = (d - u) * stepsz(i);
            dx = (rt - l) * stepsz(i);
`ifndef DIAG_EN
            if (dy != 0) dx = 0;
`endif
            mx[i][p] = clampi(mx[i][p] + dx, 0, 799);
            my[i][p] = clampi(my[i][p] + dy, 0, 599);
          end
        end else mcnt[i] = mcnt[i] + 1;
      end
    end
  endtask

  function automatic obs_t model_obs(input int i);
    obs_t o;
    o.keys = mkeys;
    o.x0 = 16'(mx[i][0]); o.y0 = 16'(my[i][0]);
    o.x1 = 16'(mx[i][1]); o.y1 = 16'(my[i][1]);
    return o;
  endfunction

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input bit r, input bit e, input bit v, input bit [7:0] b);
    @(negedge clk);
    reset_n = r; eof = e; data_valid = v; data = v ? b : 8'h00;
    model_step(r, e, v, b);
    qa.push_back(model_obs(0));
    qb.push_back(model_obs(1));
  endtask

  task automatic send(input bit [7:0] b);
    cyc(1, 0, 1, b);
    cyc(1, 0, 0, 8'h00);
  endtask

  task automatic eofp();
    cyc(1, 1, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every cycle each instance presents a state; compare it to the queued prediction.
  initial begin
    obs_t e, act;
    forever begin
      @(posedge clk);
      #1;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        act = {a_keys, 16'(a_p0x), 16'(a_p0y), 16'(a_p1x), 16'(a_p1y)};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL sb_a t=%0t: got keys=%h p0=(%0d,%0d) p1=(%0d,%0d) expected keys=%h p0=(%0d,%0d) p1=(%0d,%0d)",
                   $time, act.keys, act.x0, act.y0, act.x1, act.y1, e.keys, e.x0, e.y0, e.x1, e.y1);
        end
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        act = {b_keys, 16'(b_p0x), 16'(b_p0y), 16'(b_p1x), 16'(b_p1y)};
        checks++;
        if (act !== e) begin
          errors++;
          $display("FAIL sb_b t=%0t: got keys=%h p0=(%0d,%0d) p1=(%0d,%0d) expected keys=%h p0=(%0d,%0d) p1=(%0d,%0d)",
                   $time, act.keys, act.x0, act.y0, act.x1, act.y1, e.keys, e.x0, e.y0, e.x1, e.y1);
        end
      end
    end
  end

  initial begin
    int x_after;
    bit [7:0] b;
    do_reset();
    settle();
    chk("reset_p0x", int'(a_p0x), 200);
    chk("reset_p0y", int'(a_p0y), 300);
    chk("reset_p1x", int'(a_p1x), 600);
    chk("reset_p1y", int'(a_p1y), 300);
    chk("reset_keys", int'(a_keys), 0);

    send(8'h23);
    chk("make_23_key", int'(a_keys[3]), 1);
    eofp(); settle();
    chk("move_right", int'(a_p0x), 201);
    send(8'hF0); send(8'h23); eofp(); settle();
    chk("break_23_keys", int'(a_keys), 0);
    chk("released_stays", int'(a_p0x), 201);

    send(8'hE0); send(8'h6B);
    repeat (700) eofp();
    settle();
    chk("clamp_p1x_a", int'(a_p1x), 0);
    chk("clamp_p1x_b", int'(b_p1x), 0);
    send(8'hE0); send(8'hF0); send(8'h6B); settle();
    chk("ext_break_6b", int'(a_keys[6]), 0);

    send(8'h6B); settle();
    chk("6b_no_e0", int'(a_keys), 0);
    send(8'hE0); send(8'h15); settle();
    chk("15_with_e0", int'(a_keys), 0);
    send(8'h1C); send(8'h1A); settle();
    chk("unknown_then_idle", int'(a_keys), 8'h01);

    do_reset();
    send(8'h1A); send(8'h23); eofp(); settle();
`ifdef DIAG_EN
    x_after = 201;
`else
    x_after = 200;
`endif
    chk("up_right_x", int'(a_p0x), x_after);
    chk("up_right_y", int'(a_p0y), 299);
    send(8'hF0); send(8'h1A); send(8'h15); eofp(); settle();
    chk("left_right_x", int'(a_p0x), x_after);

    do_reset();
    send(8'h23);
    repeat (6) eofp();
    settle();
    chk("div3_step4", int'(b_p0x), 208);

    do_reset();
    cyc(1, 1, 1, 8'h23);
    cyc(1, 0, 0, 8'h00);
    settle();
    chk("byte_with_eof_x", int'(a_p0x), 200);
    chk("byte_with_eof_key", int'(a_keys), 8'h08);

    do_reset();
    send(8'hE0);
    cyc(0, 0, 0, 8'h00);
    cyc(1, 0, 0, 8'h00);
    send(8'h75); settle();
    chk("reset_aborts_e0", int'(a_keys), 0);

    for (int n = 0; n < 4000; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: b = key_code(int'($urandom_range(0, 7)));
        4, 5:       b = 8'hE0;
        6, 7:       b = 8'hF0;
        default:    b = 8'($urandom);
      endcase
      cyc(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) == 0),
          ($urandom_range(0, 2) == 0), b);
    end
    repeat (3) cyc(1, 0, 0, 8'h00);
    settle();
    settle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
